dmem_access_unit: RTL and testbench

//  MEM-stage data-port controller. Consumes the MEM-stage control bits (d_read, d_write, d_byte_enable, funct3)

---
 rtl/dmem_access_unit_pkg.sv | 50 +++++
 rtl/dmem_access_unit_if.sv | 36 +++
 rtl/dmem_access_unit_load_align.sv | 40 ++++
 rtl/dmem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_unit_pkg.sv
// ============================================================================
// Module      : dmem_access_unit_pkg
// Description : Shared types and helpers for the MEM-stage data-port
//               controller: port FSM states, load/store funct3 encodings and
//               the access-alignment rule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dport_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // funct3[1:0] carries the access size for both loads and stores
  localparam logic [1:0] C_SIZE_BYTE = 2'b00;
  localparam logic [1:0] C_SIZE_HALF = 2'b01;

  // Halfwords may sit at offsets 0..2 (they never cross the word); words
  // must be word aligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3[1:0])
      C_SIZE_BYTE: r = 1'b0;
      C_SIZE_HALF: r = (off == 2'b11);
      default:     r = (off != 2'b00);
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_access_unit_if.sv
// ============================================================================
// Module      : dmem_access_unit_if
// Description : Data-cache request/response bus.
//   data_read / data_write : request strobes, held until data_resp
//   data_mbe               : byte mask, already shifted to the byte lane
//   data_addr              : word-aligned address
//   data_wdata             : lane-shifted store data
//   data_resp              : 1-cycle completion pulse from the cache
//   data_rdata             : read word, valid with data_resp
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_access_unit_if;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;

  // Controller side
  modport master (
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    input  data_resp, data_rdata
  );

  // Cache side
  modport slave (
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    output data_resp, data_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_access_unit_load_align.sv
// ============================================================================
// Module      : dmem_access_unit_load_align
// Description : Combinational load aligner. Moves the addressed byte lane of
//               the cache word down to bit 0 and sign/zero-extends it
//               according to the load funct3.
//   rdata     in  32  raw cache word
//   lane      in  2   byte offset of the access within the word
//   funct3    in  3   load funct3 (lb/lh/lw/lbu/lhu)
//   load_word out 32  extended result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_unit_load_align
  import dmem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_word
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata >> {lane, 3'b000};

  always_comb begin
    load_word = w_shifted;
    case (funct3)
      LB:      load_word = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LBU:     load_word = {24'h000000, w_shifted[7:0]};
      LH:      load_word = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LHU:     load_word = {16'h0000, w_shifted[15:0]};
      default: load_word = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_access_unit.sv
// ============================================================================
// Module      : dmem_access_unit
// Description : MEM-stage data-port controller. Issues one cache request per
//               memory instruction, stalls the pipeline until the cache
//               responds and returns the extended load result.
//   clk, rst                 clock / synchronous active-high reset
//   mem_valid, d_read,       MEM-stage instruction and its control word
//   d_write, d_byte_en,
//   funct3, addr, store_data
//   advance                  MEM->WB register loads this cycle
//   dbus (master)            data-cache request/response bus
//   mem_stall                hold upstream stages
//   load_data                extended load result
//   misaligned               1-cycle pulse, access rejected
//   timeout_err              sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [3:0]                d_byte_en,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  input  logic                      advance,
  dmem_access_unit_if.master        dbus,
  output logic                      mem_stall,
  output logic [31:0]               load_data,
  output logic                      misaligned,
  output logic                      timeout_err
);

  localparam int unsigned C_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(TIMEOUT_CYCLES);

  dport_state_t       state_q, state_d;
  logic               data_read_q, data_read_d;
  logic               data_write_q, data_write_d;
  logic [3:0]         data_mbe_q, data_mbe_d;
  logic [31:0]        data_addr_q, data_addr_d;
  logic [31:0]        data_wdata_q, data_wdata_d;
  logic [31:0]        load_data_q, load_data_d;
  logic [1:0]         lane_q, lane_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic        w_req;
  logic        w_is_write;
  logic        w_is_read;
  logic [1:0]  w_off;
  logic        w_mis;
  logic        w_issue;
  logic [31:0] w_load_word;

  assign w_req      = mem_valid & (d_read | d_write);
  // read+write together is illegal; it resolves to a store
  assign w_is_write = d_write;
  assign w_is_read  = d_read & ~d_write;
  assign w_off      = addr[1:0];
  assign w_mis      = is_misaligned(funct3, w_off);
  assign w_issue    = (state_q == IDLE) & w_req & ~w_mis;

  // Stall and reject are combinational so the pipeline sees them in the
  // same cycle the instruction arrives.
  assign mem_stall  = w_issue | (state_q == BUSY);
  assign misaligned = (state_q == IDLE) & w_req & w_mis;

  assign dbus.data_read  = data_read_q;
  assign dbus.data_write = data_write_q;
  assign dbus.data_mbe   = data_mbe_q;
  assign dbus.data_addr  = data_addr_q;
  assign dbus.data_wdata = data_wdata_q;
  assign load_data       = load_data_q;
  assign timeout_err     = timeout_q;

  dmem_access_unit_load_align u_load_align (
    .rdata     (dbus.data_rdata),
    .lane      (lane_q),
    .funct3    (funct3_q),
    .load_word (w_load_word)
  );

  always_comb begin
    state_d      = state_q;
    data_read_d  = data_read_q;
    data_write_d = data_write_q;
    data_mbe_d   = data_mbe_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    load_data_d  = load_data_q;
    lane_d       = lane_q;
    funct3_d     = funct3_q;
    cnt_d        = '0;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE: begin
        if (w_issue) begin
          data_read_d  = w_is_read;
          data_write_d = w_is_write;
          data_mbe_d   = d_byte_en << w_off;
          data_addr_d  = {addr[31:2], 2'b00};
          data_wdata_d = store_data << {w_off, 3'b000};
          lane_d       = w_off;
          funct3_d     = funct3;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Saturating watchdog; the request is left asserted on timeout
        cnt_d = cnt_q;
        if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if ((TIMEOUT_CYCLES != 0) && (cnt_d == C_CNT_MAX)) begin
          timeout_d = 1'b1;
        end
        if (dbus.data_resp) begin
          if (data_read_q) begin
            load_data_d = w_load_word;
          end
          data_read_d  = 1'b0;
          data_write_d = 1'b0;
          cnt_d        = '0;
          state_d      = DONE;
        end
      end
      DONE: begin
        // Wait for the pipeline to take the result; never re-issue
        if (advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_read_q  <= 1'b0;
      data_write_q <= 1'b0;
      data_mbe_q   <= 4'b0000;
      data_addr_q  <= 32'h0;
      data_wdata_q <= 32'h0;
      load_data_q  <= 32'h0;
      lane_q       <= 2'b00;
      funct3_q     <= 3'b000;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_read_q  <= data_read_d;
      data_write_q <= data_write_d;
      data_mbe_q   <= data_mbe_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      load_data_q  <= load_data_d;
      lane_q       <= lane_d;
      funct3_q     <= funct3_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_valid && d_read && d_write));

  a_resp_in_busy: assert property (@(posedge clk) disable iff (rst)
    dbus.data_resp |-> (state_q == BUSY));

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Self-checking bench for dmem_access_unit: transaction-level
//               reference model compared every cycle plus directed literal
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, d_read, d_write, advance;
  logic [3:0]  d_byte_en;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        mem_stall, misaligned, timeout_err;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  dmem_access_unit_if dbus ();

  dmem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_byte_en   (d_byte_en),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .advance     (advance),
    .dbus        (dbus),
    .mem_stall   (mem_stall),
    .load_data   (load_data),
    .misaligned  (misaligned),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // An access is rejected when it would spill past the end of its word.
  function automatic bit m_mis(input logic [2:0] f3, input logic [1:0] off);
    int size;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    return (int'(off) + size) > 4;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] w, input int lane, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = (lane <= 2) ? w[8*lane +: 16] : 16'h0;
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  bit          m_busy, m_done, m_rd, m_wr, m_tmo;
  logic [31:0] m_addr, m_wdata, m_load;
  logic [3:0]  m_mbe;
  int          m_lane, m_cnt;
  logic [2:0]  m_f3;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_rd = 0; m_wr = 0; m_tmo = 0;
      m_addr = 0; m_wdata = 0; m_load = 0; m_mbe = 0; m_lane = 0; m_cnt = 0; m_f3 = 0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt >= TMO) m_tmo = 1;
      if (dbus.data_resp) begin
        if (m_rd) m_load = m_ext(dbus.data_rdata, m_lane, m_f3);
        m_busy = 0; m_done = 1; m_rd = 0; m_wr = 0; m_cnt = 0;
      end
    end else if (m_done) begin
      if (advance) m_done = 0;
    end else if (mem_valid && (d_read || d_write) && !m_mis(funct3, addr[1:0])) begin
      m_busy = 1;
      m_wr   = d_write;
      m_rd   = d_read && !d_write;
      m_lane = int'(addr[1:0]);
      m_f3   = funct3;
      m_addr = addr & 32'hFFFF_FFFC;
      m_mbe  = 4'b0000;
      m_wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (i >= m_lane) begin
          m_mbe[i] = d_byte_en[i - m_lane];
          m_wdata[8*i +: 8] = store_data[8*(i - m_lane) +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit idle, req, mis;
      idle = !m_busy && !m_done;
      req  = mem_valid && (d_read || d_write);
      mis  = m_mis(funct3, addr[1:0]);
      chk("m_stall", {31'b0, mem_stall}, {31'b0, m_busy || (idle && req && !mis)});
      chk("m_misaligned", {31'b0, misaligned}, {31'b0, idle && req && mis});
      chk("m_read", {31'b0, dbus.data_read}, {31'b0, m_busy && m_rd});
      chk("m_write", {31'b0, dbus.data_write}, {31'b0, m_busy && m_wr});
      chk("m_load_data", load_data, m_load);
      chk("m_timeout", {31'b0, timeout_err}, {31'b0, m_tmo});
      if (m_busy) begin
        chk("m_addr", dbus.data_addr, m_addr);
        chk("m_mbe", {28'b0, dbus.data_mbe}, {28'b0, m_mbe});
        chk("m_wdata", dbus.data_wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_mbe;
  logic        cap_wr;

  task automatic set_instr(input bit v, input bit rd, input bit wr, input logic [3:0] be,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    mem_valid = v; d_read = rd; d_write = wr; d_byte_en = be;
    funct3 = f3; addr = a; store_data = sd;
  endtask

  // Runs one aligned access: response after 'delay' cycles, advance held
  // low for adv_wait cycles in the completed state.
  task automatic run_access(input bit rd, input bit wr, input logic [3:0] be, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input int delay,
                            input logic [31:0] rdata, input int adv_wait,
                            output int stall_cycles, output int read_cycles);
    stall_cycles = 0;
    read_cycles  = 0;
    advance = 0;
    set_instr(1, rd, wr, be, f3, a, sd);
    for (int c = 0; c <= delay; c++) begin
      if (c == delay) begin dbus.data_resp = 1; dbus.data_rdata = rdata; end
      @(negedge clk);
      if (mem_stall) stall_cycles++;
      if (dbus.data_read) read_cycles++;
      if (c == 1) begin
        cap_addr = dbus.data_addr; cap_mbe = dbus.data_mbe;
        cap_wdata = dbus.data_wdata; cap_wr = dbus.data_write;
      end
      @(posedge clk); #1;
      dbus.data_resp = 0;
      dbus.data_rdata = 32'h0;
    end
    for (int c = 0; c <= adv_wait; c++) begin
      if (c == adv_wait) advance = 1;
      @(negedge clk);
      if (mem_stall) stall_cycles++;
      if (dbus.data_read) read_cycles++;
      @(posedge clk); #1;
    end
    advance = 0;
    set_instr(0, 0, 0, 4'b0000, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int st, rc;
    rst = 1;
    advance = 0;
    dbus.data_resp = 0;
    dbus.data_rdata = 32'h0;
    set_instr(0, 0, 0, 4'b0000, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;

    @(negedge clk);
    chk("rst_read", {31'b0, dbus.data_read}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_addr", dbus.data_addr, 32'h0);
    chk("rst_tmo", {31'b0, timeout_err}, 32'd0);
    @(posedge clk); #1;

    // lw 0x100, response 3 cycles after the request cycle
    run_access(1, 0, 4'b1111, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, st, rc);
    chk("lw_stall_cycles", st, 4);
    chk("lw_read_cycles", rc, 3);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_mbe", {28'b0, cap_mbe}, 32'hF);
    chk("lw_load", load_data, 32'hDEADBEEF);

    // lb / lbu at byte 3
    run_access(1, 0, 4'b0001, 3'b000, 32'h103, 32'h0, 2, 32'h80112233, 0, st, rc);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_mbe", {28'b0, cap_mbe}, 32'h8);
    chk("lb_load", load_data, 32'hFFFFFF80);
    run_access(1, 0, 4'b0001, 3'b100, 32'h103, 32'h0, 2, 32'h80112233, 0, st, rc);
    chk("lbu_load", load_data, 32'h00000080);

    // sh at offset 2; load_data must not change
    run_access(0, 1, 4'b0011, 3'b001, 32'h202, 32'h0000ABCD, 2, 32'h12345678, 0, st, rc);
    chk("sh_write", {31'b0, cap_wr}, 32'd1);
    chk("sh_mbe", {28'b0, cap_mbe}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD0000);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_read_cycles", rc, 0);
    chk("sh_load_kept", load_data, 32'h00000080);

    // lh at offset 1 (legal), lhu at offset 2
    run_access(1, 0, 4'b0011, 3'b001, 32'h101, 32'h0, 1, 32'h11ABCD22, 0, st, rc);
    chk("lh_mbe", {28'b0, cap_mbe}, 32'h6);
    chk("lh_load", load_data, 32'hFFFFABCD);
    run_access(1, 0, 4'b0011, 3'b101, 32'h302, 32'h0, 1, 32'h80017FFF, 0, st, rc);
    chk("lhu_load", load_data, 32'h00008001);

    // misaligned lw and lh: one-cycle reject, no request, no stall
    set_instr(1, 1, 0, 4'b1111, 3'b010, 32'h102, 32'h0);
    @(negedge clk);
    chk("mis_lw_pulse", {31'b0, misaligned}, 32'd1);
    chk("mis_lw_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    set_instr(1, 1, 0, 4'b0011, 3'b001, 32'h103, 32'h0);
    @(negedge clk);
    chk("mis_lh_pulse", {31'b0, misaligned}, 32'd1);
    @(posedge clk); #1;
    set_instr(0, 0, 0, 4'b0000, 3'b000, 32'h0, 32'h0);
    rc = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dbus.data_read || misaligned) rc++;
      @(posedge clk); #1;
    end
    chk("mis_no_request", rc, 0);

    // completion held with advance low for 5 cycles
    run_access(1, 0, 4'b1111, 3'b010, 32'h104, 32'h0, 1, 32'hCAFEF00D, 5, st, rc);
    chk("hold_stall_cycles", st, 2);
    chk("hold_read_cycles", rc, 1);
    chk("hold_load", load_data, 32'hCAFEF00D);

    // watchdog: no response
    set_instr(1, 1, 0, 4'b1111, 3'b010, 32'h400, 32'h0);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 8) chk("tmo_before", {31'b0, timeout_err}, 32'd0);
      if (c == 9) begin
        chk("tmo_after", {31'b0, timeout_err}, 32'd1);
        chk("tmo_req_held", {31'b0, dbus.data_read}, 32'd1);
      end
      @(posedge clk); #1;
    end
    rst = 1;
    set_instr(0, 0, 0, 4'b0000, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst2_read", {31'b0, dbus.data_read}, 32'd0);
    chk("rst2_write", {31'b0, dbus.data_write}, 32'd0);
    chk("rst2_mbe", {28'b0, dbus.data_mbe}, 32'd0);
    chk("rst2_addr", dbus.data_addr, 32'h0);
    chk("rst2_wdata", dbus.data_wdata, 32'h0);
    chk("rst2_load", load_data, 32'h0);
    chk("rst2_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst2_tmo", {31'b0, timeout_err}, 32'd0);
    @(posedge clk); #1;

    // unit is usable again after reset
    run_access(1, 0, 4'b0001, 3'b000, 32'h501, 32'h0, 2, 32'h00007F00, 0, st, rc);
    chk("post_rst_lb", load_data, 32'h0000007F);
    chk("post_rst_stall", st, 3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
